// File: rtl/spike_event_segmenter.sv
// spike_event_segmenter: turns a per-cycle detection stream into timestamped
// events {start, len}. Runs shorter than MIN_WIDTH are discarded, runs are
// capped at MAX_WIDTH, and each emitted event is followed by a refractory
// gap of REFRACT cycles. Events wait in a small FIFO for the consumer.
// Optional feature: define SPIKE_SEG_DROP_CNT_EN to add the drop_count output.
module spike_event_segmenter #(
    parameter int unsigned MIN_WIDTH  = 3,
    parameter int unsigned MAX_WIDTH  = 1024,
    parameter int unsigned REFRACT    = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        det_in,
    input  logic        event_ready,
    output logic        event_valid,
    output logic [31:0] event_start,
    output logic [15:0] event_len,
    output logic        overflow
`ifdef SPIKE_SEG_DROP_CNT_EN
    ,
    output logic [15:0] drop_count
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] MaxLen = 16'(MAX_WIDTH);
    localparam logic [15:0] MinLen = 16'(MIN_WIDTH);
    localparam logic [31:0] RefrLast = 32'(REFRACT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StRefract
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] ts_q;
    logic        det_prev_q;
    // Set once a low det_in has been seen since reset, so a level held high
    // through reset cannot look like a fresh rising edge.
    logic        armed_q;
    logic [31:0] start_q, start_d;
    logic [15:0] len_q, len_d;
    logic [31:0] refr_q, refr_d;

    logic        push;
    logic [15:0] push_len;

    logic [47:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        empty, full, pop, push_ok, drop;

    // Timestamp, edge detector history and FSM registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q       <= '0;
            det_prev_q <= 1'b0;
            armed_q    <= 1'b0;
            state_q    <= StIdle;
            start_q    <= '0;
            len_q      <= '0;
            refr_q     <= '0;
        end else begin
            ts_q       <= ts_q + 32'd1;
            det_prev_q <= det_in;
            armed_q    <= armed_q | ~det_in;
            state_q    <= state_d;
            start_q    <= start_d;
            len_q      <= len_d;
            refr_q     <= refr_d;
        end
    end

    // Segmentation FSM: run tracking, length checks and event push request.
    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        len_d    = len_q;
        refr_d   = refr_q;
        push     = 1'b0;
        push_len = len_q;
        unique case (state_q)
            StIdle: begin
                if (det_in && !det_prev_q && armed_q) begin
                    state_d = StRun;
                    start_d = ts_q;
                    len_d   = 16'd1;
                end
            end
            StRun: begin
                if (det_in) begin
                    len_d = len_q + 16'd1;
                    if (len_d == MaxLen) begin
                        push     = 1'b1;
                        push_len = MaxLen;
                        state_d  = StRefract;
                        refr_d   = '0;
                    end
                end else if (len_q >= MinLen) begin
                    push    = 1'b1;
                    state_d = StRefract;
                    refr_d  = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StRefract: begin
                if (refr_q == RefrLast) begin
                    state_d = StIdle;
                end else begin
                    refr_d = refr_q + 32'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop     = !empty && event_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    // FIFO pointers and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (drop) overflow <= 1'b1;
        end
    end

    // FIFO storage; contents need no reset because empty masks the outputs.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr_q[AW-1:0]] <= {start_q, push_len};
        end
    end

    // Head-of-queue outputs, zero while the queue is empty.
    always_comb begin
        event_valid = !empty;
        event_start = '0;
        event_len   = '0;
        if (!empty) begin
            {event_start, event_len} = mem[rd_ptr_q[AW-1:0]];
        end
    end

`ifdef SPIKE_SEG_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    // Saturating count of dropped events.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (drop && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_spike_event_segmenter.sv
// Bench for spike_event_segmenter: constant-table scenario, hand sequences for
// the multi-cycle corners, then random traffic against a reference model.
module tb_spike_event_segmenter;

    localparam int MINW  = 3;
    localparam int MAXW  = 1024;
    localparam int REFR  = 8;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        det_in = 1'b0;
    logic        event_ready = 1'b0;
    logic        event_valid;
    logic [31:0] event_start;
    logic [15:0] event_len;
    logic        overflow;
`ifdef SPIKE_SEG_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    spike_event_segmenter #(
        .MIN_WIDTH (MINW),
        .MAX_WIDTH (MAXW),
        .REFRACT   (REFR),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .det_in     (det_in),
        .event_ready(event_ready),
        .event_valid(event_valid),
        .event_start(event_start),
        .event_len  (event_len),
        .overflow   (overflow)
`ifdef SPIKE_SEG_DROP_CNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state, in terms of runs, dead time and an event queue.
    typedef struct {
        logic [31:0] s;
        logic [15:0] l;
    } ev_t;
    ev_t         q[$];
    bit          m_in_run, m_prev, m_seen_low, m_ovf;
    int unsigned m_ts, m_start;
    int          m_len, m_dead, m_drops;

    function automatic void model_step(bit r, bit d, bit rdy);
        bit  pop;
        bit  have;
        ev_t e;
        if (r) begin
            q.delete();
            m_in_run = 0; m_prev = 0; m_seen_low = 0; m_ovf = 0;
            m_ts = 0; m_start = 0; m_len = 0; m_dead = 0; m_drops = 0;
            return;
        end
        pop  = (q.size() > 0) && rdy;
        have = 0;
        if (m_dead > 0) begin
            m_dead--;
        end else if (m_in_run) begin
            if (d) begin
                m_len++;
                if (m_len == MAXW) begin
                    have = 1; m_in_run = 0; m_dead = REFR;
                end
            end else begin
                m_in_run = 0;
                if (m_len >= MINW) begin
                    have = 1; m_dead = REFR;
                end
            end
        end else if (d && !m_prev && m_seen_low) begin
            m_in_run = 1; m_start = m_ts; m_len = 1;
        end
        if (!d) m_seen_low = 1;
        m_prev = d;
        m_ts   = m_ts + 1;
        if (pop) void'(q.pop_front());
        if (have) begin
            e.s = m_start;
            e.l = 16'(m_len);
            if (q.size() < DEPTH) q.push_back(e);
            else begin
                m_ovf = 1;
                if (m_drops < 65535) m_drops++;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at time %0t", name, got, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit d, input bit rdy);
        rst = r; det_in = d; event_ready = rdy;
        model_step(r, d, rdy);
        @(posedge clk);
        #1;
        chk("model_valid", {31'd0, event_valid}, {31'd0, q.size() > 0});
        chk("model_start", event_start, (q.size() > 0) ? q[0].s : 32'd0);
        chk("model_len", {16'd0, event_len}, (q.size() > 0) ? {16'd0, q[0].l} : 32'd0);
        chk("model_overflow", {31'd0, overflow}, {31'd0, m_ovf});
`ifdef SPIKE_SEG_DROP_CNT_EN
        chk("model_drop_count", {16'd0, drop_count}, 32'(m_drops));
`endif
    endtask

    task automatic steps(input int n, input bit d, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, d, rdy);
    endtask

    task automatic expect_head(input string name, input bit v, input int s, input int l);
        chk({name, "_valid"}, {31'd0, event_valid}, {31'd0, v});
        chk({name, "_start"}, event_start, 32'(s));
        chk({name, "_len"}, {16'd0, event_len}, 32'(l));
    endtask

    typedef struct {
        bit          r;
        bit          d;
        bit          rdy;
        int          n;
        bit          ev;
        logic [31:0] es;
        logic [15:0] el;
    } vec_t;
    vec_t tbl[10];

    initial begin
        bit d;
        // Basic event, latency, short-run discard, minimum-length event.
        tbl[0] = '{1, 0, 1, 1,  0, 0,  0};
        tbl[1] = '{0, 0, 1, 10, 0, 0,  0};
        tbl[2] = '{0, 1, 1, 5,  0, 0,  0};
        tbl[3] = '{0, 0, 1, 1,  1, 10, 5};
        tbl[4] = '{0, 0, 1, 1,  0, 0,  0};
        tbl[5] = '{0, 0, 1, 8,  0, 0,  0};
        tbl[6] = '{0, 1, 1, 2,  0, 0,  0};
        tbl[7] = '{0, 0, 1, 1,  0, 0,  0};
        tbl[8] = '{0, 1, 1, 3,  0, 0,  0};
        tbl[9] = '{0, 0, 1, 1,  1, 28, 3};

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < tbl[i].n; k++) step(tbl[i].r, tbl[i].d, tbl[i].rdy);
            expect_head($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].es, tbl[i].el);
        end
        chk("tbl_overflow", {31'd0, overflow}, 32'd0);

        // Level held high through reset must not start an event.
        step(1, 1, 1);
        steps(6, 1, 1);
        steps(1, 0, 1);
        expect_head("held_through_rst", 0, 0, 0);

        // Re-trigger during refractory is ignored.
        step(1, 0, 0);
        steps(20, 0, 0);
        steps(4, 1, 0);
        steps(4, 0, 0);
        steps(6, 1, 0);
        steps(12, 0, 0);
        expect_head("refract_one", 1, 20, 4);
        steps(1, 0, 1);
        expect_head("refract_drained", 0, 0, 0);

        // Length cap and no re-trigger while still high.
        step(1, 0, 0);
        steps(100, 0, 0);
        steps(1100, 1, 0);
        expect_head("cap", 1, 100, 1024);
        steps(1, 1, 1);
        steps(20, 1, 0);
        expect_head("cap_no_second", 0, 0, 0);
        steps(1, 0, 0);
        steps(5, 1, 0);
        steps(1, 0, 0);
        expect_head("cap_new_edge", 1, 1222, 5);

        // Full FIFO with stalled consumer, then in-order drain.
        step(1, 0, 0);
        steps(2, 0, 0);
        for (int p = 0; p < 5; p++) begin
            steps(3, 1, 0);
            steps(10, 0, 0);
        end
        chk("ovf_set", {31'd0, overflow}, 32'd1);
`ifdef SPIKE_SEG_DROP_CNT_EN
        chk("ovf_drop_count", {16'd0, drop_count}, 32'd1);
`endif
        for (int p = 0; p < 4; p++) begin
            expect_head($sformatf("drain%0d", p), 1, 2 + 13 * p, 3);
            steps(1, 0, 1);
        end
        expect_head("drain_empty", 0, 0, 0);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Reset mid-run discards it; timestamps restart from zero.
        step(1, 0, 1);
        steps(3, 0, 1);
        steps(2, 1, 1);
        step(1, 1, 1);
        expect_head("midrun_rst", 0, 0, 0);
        chk("midrun_rst_ovf", {31'd0, overflow}, 32'd0);
        steps(2, 0, 0);
        steps(4, 1, 0);
        steps(1, 0, 0);
        expect_head("after_rst", 1, 2, 4);

        // Random traffic against the model.
        step(1, 0, 1);
        d = 0;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 3) == 0) d = ~d;
            step(($urandom_range(0, 799) == 0), d, ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
